mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-access stage of the 16-bit RISC pipeline; sits directly upstream of the 64-word data memory.
- Accepts one EX-stage request at a time and computes the effective address.
- Sequences the memory's level-sensitive addr/din/wea so that stores are glitch-free and loads are captured cleanly.
- Delivers a registered result to the writeback stage; non-memory ops pass through in one cycle.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width driven to the data memory
- DEPTH, 64, number of valid memory words; an effective address >= DEPTH faults
- REG_W, 4, destination register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_base  in  ADDR_W  base register value
- req_offset  in  ADDR_W  offset, already sign-extended
- req_wdata  in  DATA_W  store data
- req_alu  in  DATA_W  ALU result, used for pass-through ops
- req_dest  in  REG_W  destination register index
- dm_addr  out  ADDR_W  address to data memory
- dm_din  out  DATA_W  write data to data memory
- dm_wea  out  1  write enable to data memory
- dm_dout  in  DATA_W  read data from data memory
- wb_valid  out  1  one-cycle result strobe
- wb_we  out  1  writeback should write the register file
- wb_dest  out  REG_W  destination index
- wb_data  out  DATA_W  result data
- wb_fault  out  1  access faulted (out of range or illegal op)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state changes on rising clk.
- Reset values: state=IDLE, req_ready=1, dm_addr=0, dm_din=0, dm_wea=0, wb_valid=0, wb_we=0, wb_dest=0, wb_data=0, wb_fault=0.
- Reset mid-operation: abandons the request with no wb_valid. dm_wea is forced 0 at that edge, so a store that was in WR_STROBE is cut short.
- Accept: req_valid && req_ready at a rising edge. req_ready=1 only in IDLE.
- Effective address: ea = req_base + req_offset, modulo 2^ADDR_W (wrap, no carry out). ea is registered at accept.
- Fault: (ea >= DEPTH) or (req_load && req_store).
  - No memory access occurs; dm_wea stays 0.
  - Next cycle: wb_valid=1, wb_fault=1, wb_we=0, wb_data=0. Return to IDLE.
- Pass-through (neither load nor store):
  - Next cycle: wb_valid=1, wb_we=1, wb_data=req_alu, wb_fault=0.
  - Stays IDLE, so back-to-back accepts are allowed every cycle.
- Load:
  - Accept -> RD. In RD: dm_addr=ea, dm_wea=0, req_ready=0.
  - At the end of RD, capture dm_dout into wb_data.
  - Next cycle: wb_valid=1, wb_we=1. State -> IDLE.
  - Latency: wb_valid 2 cycles after the accept edge.
- Store:
  - Accept -> WR_SETUP: dm_addr=ea, dm_din=wdata, dm_wea=0.
  - -> WR_STROBE: dm_wea=1, addr/din unchanged.
  - -> WR_HOLD: dm_wea=0, addr/din unchanged. The falling wea refreshes the memory's dout.
  - -> IDLE with wb_valid=1, wb_we=0, wb_data=0, wb_fault=0.
  - Latency: 4 cycles. dm_addr and dm_din must not change in any cycle where dm_wea=1 or in the cycle adjacent to it.
- Outside a load or store:
  - dm_addr and dm_din hold their last values, to avoid spurious memory events.
  - dm_wea is 1 only in WR_STROBE.
- wb_valid is high for exactly one cycle per accepted request; wb_* hold their values until the next result.
- Requests that arrive while req_ready=0 are not consumed. The upstream stage holds them stable.

Test Plan:
- Reset, then load base=16 offset=0 -> dm_addr=16, wea never 1; wb_data=0x0101, wb_we=1, wb_valid exactly 2 cycles after accept.
- Store base=20 offset=2 wdata=0xBEEF, then load ea=22 -> wea high exactly one cycle with dm_addr=22 stable ±1 cycle; load returns 0xBEEF; store latency 4; req_ready low during the store.
- Pass-through req_alu=0x1234 on 3 consecutive cycles -> wb_valid on 3 consecutive cycles, wb_data=0x1234 each, req_ready stays 1.
- Load base=0xFFFF offset=0x0041 (ea wraps to 0x0040=64) -> wb_fault=1, wb_we=0, dm_wea=0; also req_load=req_store=1 -> fault.
- Assert reset during WR_STROBE -> next cycle dm_wea=0, state IDLE, req_ready=1, no wb_valid.
- Load at ea=5 with req_valid held high while busy -> second request accepted only after return to IDLE; no duplicate wb_valid.

Source files
------------

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Memory-access stage that sequences a 64-word level-sensitive data
//            memory and returns registered results to the writeback stage.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_alu,
    input  logic [REG_W-1:0]  req_dest,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_wea,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_fault
);

    localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD        = 3'd1,
        WR_SETUP  = 3'd2,
        WR_STROBE = 3'd3,
        WR_HOLD   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] w_ea;
    logic              w_accept;
    logic              w_fault;
    logic [REG_W-1:0]  r_dest;

    assign req_ready = (state == IDLE);
    assign w_ea      = req_base + req_offset;
    assign w_accept  = req_valid && req_ready;
    assign w_fault   = (w_ea >= c_depth) || (req_load && req_store);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_accept && !w_fault) begin
                    if (req_load) begin
                        state_next = RD;
                    end else if (req_store) begin
                        state_next = WR_SETUP;
                    end
                end
            end
            RD:        state_next = IDLE;
            WR_SETUP:  state_next = WR_STROBE;
            WR_STROBE: state_next = WR_HOLD;
            WR_HOLD:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // dm_wea is registered from the next state so the memory sees a clean,
    // single-cycle strobe while addr/din were already settled a cycle earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            dm_addr  <= '0;
            dm_din   <= '0;
            dm_wea   <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
            wb_fault <= 1'b0;
            r_dest   <= '0;
        end else begin
            wb_valid <= 1'b0;
            dm_wea   <= (state_next == WR_STROBE);
            case (state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= '0;
                            wb_fault <= 1'b1;
                            wb_dest  <= req_dest;
                        end else if (!req_load && !req_store) begin
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b1;
                            wb_data  <= req_alu;
                            wb_fault <= 1'b0;
                            wb_dest  <= req_dest;
                        end else begin
                            dm_addr <= w_ea;
                            r_dest  <= req_dest;
                            if (req_store) begin
                                dm_din <= req_wdata;
                            end
                        end
                    end
                end
                RD: begin
                    wb_valid <= 1'b1;
                    wb_we    <= 1'b1;
                    wb_data  <= dm_dout;
                    wb_fault <= 1'b0;
                    wb_dest  <= r_dest;
                end
                WR_HOLD: begin
                    wb_valid <= 1'b1;
                    wb_we    <= 1'b0;
                    wb_data  <= '0;
                    wb_fault <= 1'b0;
                    wb_dest  <= r_dest;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu with a 64-word memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [15:0] req_base;
    logic [15:0] req_offset;
    logic [15:0] req_wdata;
    logic [15:0] req_alu;
    logic [3:0]  req_dest;
    logic [15:0] dm_addr;
    logic [15:0] dm_din;
    logic        dm_wea;
    logic [15:0] dm_dout;
    logic        wb_valid;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_fault;

    always #5 clk = ~clk;

    mem_stage_lsu #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH (64),
        .REG_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_load  (req_load),
        .req_store (req_store),
        .req_base  (req_base),
        .req_offset(req_offset),
        .req_wdata (req_wdata),
        .req_alu   (req_alu),
        .req_dest  (req_dest),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_wea    (dm_wea),
        .dm_dout   (dm_dout),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .wb_fault  (wb_fault)
    );

    // Data memory: asynchronous read, written while wea is high.
    logic [15:0] mem [64];
    assign dm_dout = mem[dm_addr[5:0]];
    always @(posedge clk) begin
        if (dm_wea) mem[dm_addr[5:0]] <= dm_din;
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [15:0] base;
        logic [15:0] off;
        logic [15:0] wdata;
        logic [15:0] alu;
        logic [3:0]  dest;
        logic [15:0] exp_data;
        logic        exp_we;
        logic        exp_fault;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        we;
        logic        fault;
        logic [3:0]  dest;
        int          due;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   wea_cycles = 0;
    logic        prev_wea = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [15:0] base,
                                input logic [15:0] off, input logic [15:0] wdata,
                                input logic [15:0] alu, input logic [3:0] dest,
                                input logic [15:0] ed, input logic ewe, input logic ef,
                                input int lat, input int busy);
        vec_t v;
        v.ld = ld; v.st = st; v.base = base; v.off = off; v.wdata = wdata; v.alu = alu;
        v.dest = dest; v.exp_data = ed; v.exp_we = ewe; v.exp_fault = ef;
        v.exp_lat = lat; v.exp_busy = busy;
        return v;
    endfunction

    // Output monitor: pops the scoreboard on each result and watches the strobe.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!reset) begin
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                    chk("wb_we", 32'(wb_we), 32'(e.we));
                    chk("wb_fault", 32'(wb_fault), 32'(e.fault));
                    chk("wb_dest", 32'(wb_dest), 32'(e.dest));
                    chk("latency", 32'(cyc), 32'(e.due));
                end
            end
            if (dm_wea || prev_wea) begin
                chk("addr_stable", 32'(dm_addr), 32'(prev_addr));
                chk("din_stable", 32'(dm_din), 32'(prev_din));
            end
            if (dm_wea && prev_wea) chk("wea_one_cycle", 32'd1, 32'd0);
            if (dm_wea) wea_cycles++;
        end
        prev_wea  = dm_wea;
        prev_addr = dm_addr;
        prev_din  = dm_din;
    end

    task automatic apply(input vec_t v, input int exp_wait);
        int   waited;
        logic got;
        exp_t e;
        waited = 0;
        got = 1'b0;
        req_load = v.ld; req_store = v.st; req_base = v.base; req_offset = v.off;
        req_wdata = v.wdata; req_alu = v.alu; req_dest = v.dest; req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                e.data = v.exp_data; e.we = v.exp_we; e.fault = v.exp_fault;
                e.dest = v.dest; e.due = cyc + 1 + v.exp_lat;
                sb.push_back(e);
                got = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            waited++;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        else chk("busy_wait", 32'(waited), 32'(exp_wait));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        vec_t pv;
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
        mem[16] = 16'h0101;

        vecs[0]  = mk(1, 0, 16'd16,   16'd0,    16'h0,    16'h0,    4'd1,  16'h0101, 1, 0, 1, 1);
        vecs[1]  = mk(0, 1, 16'd20,   16'd2,    16'hBEEF, 16'h0,    4'd2,  16'h0000, 0, 0, 3, 3);
        vecs[2]  = mk(1, 0, 16'd16,   16'd6,    16'h0,    16'h0,    4'd3,  16'hBEEF, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0, 16'd0,    16'd0,    16'h0,    16'h1234, 4'd4,  16'h1234, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 16'd0,    16'd0,    16'h0,    16'h1234, 4'd5,  16'h1234, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 16'd0,    16'd0,    16'h0,    16'h1234, 4'd6,  16'h1234, 1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 16'hFFFF, 16'h0041, 16'h0,    16'h0,    4'd7,  16'h0000, 0, 1, 0, 0);
        vecs[7]  = mk(1, 1, 16'd3,    16'd0,    16'h0,    16'h0,    4'd8,  16'h0000, 0, 1, 0, 0);
        vecs[8]  = mk(1, 0, 16'd8,    16'hFFFD, 16'h0,    16'h0,    4'd9,  16'hA005, 1, 0, 1, 1);
        vecs[9]  = mk(0, 0, 16'd0,    16'd0,    16'h0,    16'h5555, 4'd10, 16'h5555, 1, 0, 0, 0);
        vecs[10] = mk(1, 0, 16'h0040, 16'hFFFF, 16'h0,    16'h0,    4'd11, 16'hA03F, 1, 0, 1, 1);
        vecs[11] = mk(0, 1, 16'h0030, 16'h000F, 16'h1357, 16'h0,    4'd12, 16'h0000, 0, 0, 3, 3);
        vecs[12] = mk(1, 0, 16'h003F, 16'd0,    16'h0,    16'h0,    4'd13, 16'h1357, 1, 0, 1, 1);
        vecs[13] = mk(0, 1, 16'h0040, 16'd0,    16'hFFFF, 16'h0,    4'd14, 16'h0000, 0, 1, 0, 0);

        reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_base = '0; req_offset = '0; req_wdata = '0; req_alu = '0; req_dest = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_dm_din", 32'(dm_din), 32'd0);
        chk("rst_dm_wea", 32'(dm_wea), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_fault", 32'(wb_fault), 32'd0);
        reset = 1'b0;

        // Requests are presented back to back; each waits while the stage is busy.
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], (i == 0) ? 0 : vecs[i-1].exp_busy);
        end
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("wea_cycles", 32'(wea_cycles), 32'd2);

        // Reset while the write strobe is high cuts the store short.
        req_load = 1'b0; req_store = 1'b1; req_base = 16'd30; req_offset = 16'd0;
        req_wdata = 16'hDEAD; req_dest = 4'd15; req_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_store_accept", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2;
            if (dm_wea) begin
                found = 1'b1;
                break;
            end
        end
        chk("strobe_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("cut_dm_wea", 32'(dm_wea), 32'd0);
        chk("cut_req_ready", 32'(req_ready), 32'd1);
        chk("cut_wb_valid", 32'(wb_valid), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        pv = mk(0, 0, 16'd0, 16'd0, 16'h0, 16'h7777, 4'd3, 16'h7777, 1, 0, 0, 0);
        apply(pv, 0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
